// File: rtl/fpu_pkg.sv
// Shared FP op codes and issue-controller state encoding; the FBU decoder
// uses the same constants so both sides agree on which codes are legal.
package fpu_pkg;

  localparam logic [4:0] FOP_ADD       = 5'd0;
  localparam logic [4:0] FOP_SUB       = 5'd1;
  localparam logic [4:0] FOP_FCLASS    = 5'd2;
  localparam logic [4:0] FOP_FCVT_S_W  = 5'd3;
  localparam logic [4:0] FOP_FCVT_S_WU = 5'd4;
  localparam logic [4:0] FOP_FCVT_W_S  = 5'd5;
  localparam logic [4:0] FOP_MUL       = 5'd6;
  localparam logic [4:0] FOP_DIV       = 5'd7;
  localparam logic [4:0] FOP_FEQ       = 5'd8;
  localparam logic [4:0] FOP_FLT       = 5'd9;
  localparam logic [4:0] FOP_FLE       = 5'd10;
  localparam logic [4:0] FOP_FMIN      = 5'd11;
  localparam logic [4:0] FOP_FMAX      = 5'd12;
  localparam logic [4:0] FOP_FSGNJ     = 5'd13;
  localparam logic [4:0] FOP_FSGNJN    = 5'd14;
  localparam logic [4:0] FOP_FSGNJX    = 5'd15;
  localparam logic [4:0] FOP_FMADD     = 5'd16;
  localparam logic [4:0] FOP_FMSUB     = 5'd17;
  localparam logic [4:0] FOP_FNMADD    = 5'd18;
  localparam logic [4:0] FOP_FNMSUB    = 5'd19;
  localparam logic [4:0] FOP_FCVT_WU_S = 5'd20;
  localparam logic [4:0] FOP_FSQRT     = 5'd21;
  localparam logic [4:0] FOP_LAST      = FOP_FSQRT;
  localparam logic [4:0] FOP_IDLE      = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } issue_state_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    return op <= FOP_LAST;
  endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Clear/enable up-counter that bounds how long the FBU may take; tc marks
// the last permitted cycle (count == TIMEOUT-1) and the count parks there.
module fpu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)         count <= '0;
    else if (clr)       count <= '0;
    else if (en && !tc) count <= count + CW'(1);
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// EX-stage controller for the FBU: latches one FP request, holds it stable
// until fbu_done (or watchdog abort), and returns a one-cycle writeback pulse.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [WIDTH-1:0] req_rs3,
  input  logic             flush,
  output logic [4:0]       fbu_op,
  output logic [WIDTH-1:0] fbu_rs1,
  output logic [WIDTH-1:0] fbu_rs2,
  output logic [WIDTH-1:0] fbu_rs3,
  input  logic [WIDTH-1:0] fbu_rd,
  input  logic             fbu_done,
  output logic             stall,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_err,
  output logic             busy
);

  issue_state_t state_q, state_d;
  logic [4:0]   op_q;
  logic         accept;
  logic         wd_run;
  logic         wd_tc;

  assign accept = (state_q == ST_IDLE) && req_valid && !flush;
  assign wd_run = (state_q == ST_BUSY) || (state_q == ST_DRAIN);

  fpu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!wd_run),
    .en    (wd_run),
    .tc    (wd_tc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Done outranks both the watchdog and flush; flush+done discards the result.
  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = is_legal_op(req_op) ? ST_BUSY : ST_RESP;
      ST_BUSY: begin
        if (fbu_done)   state_d = flush ? ST_IDLE : ST_RESP;
        else if (flush) state_d = ST_DRAIN;
        else if (wd_tc) state_d = ST_RESP;
      end
      ST_DRAIN: if (fbu_done || wd_tc) state_d = ST_IDLE;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The op is only exposed while a sub-unit is working, so FOP_IDLE always
  // separates two transactions.
  always_comb begin
    fbu_op   = FOP_IDLE;
    stall    = 1'b0;
    wb_valid = 1'b0;
    unique case (state_q)
      ST_IDLE:  stall = req_valid && !flush;
      ST_BUSY: begin
        fbu_op = op_q;
        stall  = !flush;
      end
      ST_DRAIN: fbu_op = op_q;
      ST_RESP:  wb_valid = 1'b1;
      default:  ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // The writeback registers load only on RESP entry, so they hold between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= FOP_IDLE;
      fbu_rs1 <= '0;
      fbu_rs2 <= '0;
      fbu_rs3 <= '0;
      wb_data <= '0;
      wb_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        fbu_rs1 <= req_rs1;
        fbu_rs2 <= req_rs2;
        fbu_rs3 <= req_rs3;
      end
      if (state_d == ST_RESP) begin
        if ((state_q == ST_BUSY) && fbu_done) begin
          wb_data <= fbu_rd;
          wb_err  <= 1'b0;
        end else begin
          wb_data <= '0;
          wb_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed vector table, hand-written
// multi-cycle sequences and random transactions against a transaction-level model.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int W      = 32;
  localparam int T      = 8;
  localparam int BUDGET = 4 * T + 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [4:0]   req_op;
  logic [W-1:0] req_rs1, req_rs2, req_rs3;
  logic         flush;
  logic [4:0]   fbu_op;
  logic [W-1:0] fbu_rs1, fbu_rs2, fbu_rs3;
  logic [W-1:0] fbu_rd;
  logic         fbu_done;
  logic         stall, wb_valid, wb_err, busy;
  logic [W-1:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .flush(flush),
    .fbu_op(fbu_op), .fbu_rs1(fbu_rs1), .fbu_rs2(fbu_rs2), .fbu_rs3(fbu_rs3),
    .fbu_rd(fbu_rd), .fbu_done(fbu_done), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
  );

  // FBU stub: done after stub_lat cycles of a non-idle op (0 = never finishes).
  int           stub_lat;
  logic         stub_fixed_en;
  logic [W-1:0] stub_fixed;
  int           op_cnt;

  function automatic logic [W-1:0] stub_fn(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c);
    return (a ^ {b[15:0], b[31:16]}) + c + {27'd0, op};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || fbu_op == FOP_IDLE) op_cnt <= 0;
    else                              op_cnt <= op_cnt + 1;
  end

  assign fbu_done = (fbu_op != FOP_IDLE) && (stub_lat != 0) && (op_cnt == stub_lat - 1);
  assign fbu_rd   = stub_fixed_en ? stub_fixed : stub_fn(fbu_op, fbu_rs1, fbu_rs2, fbu_rs3);

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] rs1, rs2, rs3;
    int           lat;       // cycles of non-idle op until done, 0 = hung
    int           flush_at;  // cycle index of flush, 0 = none
    logic         fixed_en;
    logic [W-1:0] fixed_rd;
    int           wb_cnt;    // expected number of wb_valid pulses
    int           wb_cycle;
    logic [W-1:0] data;
    logic         err;
    int           stall;     // expected number of stalled cycles
    int           idle;      // first cycle back in IDLE
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: computed from latency, flush point and timeout.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic done_ok;
    int   e;
    if (v.op > FOP_LAST) begin
      r.wb_cnt = 1; r.wb_cycle = 1; r.data = '0; r.err = 1'b1; r.stall = 1; r.idle = 2;
    end else begin
      done_ok = (v.lat != 0) && (v.lat <= T);
      e       = done_ok ? v.lat : T;
      if (v.flush_at != 0) begin
        r.wb_cnt = 0; r.wb_cycle = 0; r.data = '0; r.err = 1'b0;
        r.stall = v.flush_at; r.idle = e + 1;
      end else begin
        r.wb_cnt = 1; r.wb_cycle = e + 1;
        r.data   = done_ok ? stub_fn(v.op, v.rs1, v.rs2, v.rs3) : '0;
        r.err    = !done_ok;
        r.stall  = e + 1; r.idle = e + 2;
      end
    end
    return r;
  endfunction

  // Drives one instruction from cycle 0 and observes until the block is idle.
  task automatic run_vec(input vec_t v, input string tag);
    int           wb_cnt = 0, wb_cycle = -1, stall_cnt = 0, idle = -1, op_bad = 0;
    int           busy_end;
    logic [W-1:0] data_seen = '0;
    logic         err_seen = 1'b0;
    logic         wb_seen = 1'b0;
    logic [4:0]   exp_op;
    busy_end = (v.wb_cnt > 0) ? v.wb_cycle - 1 : v.idle - 1;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        stub_lat = v.lat; stub_fixed_en = v.fixed_en; stub_fixed = v.fixed_rd;
        req_op = v.op; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rs3 = v.rs3;
      end
      req_valid = (c == 0) || (!wb_seen && (v.flush_at == 0 || c <= v.flush_at));
      flush     = (v.flush_at != 0) && (c == v.flush_at);
      @(negedge clk);
      if (stall) stall_cnt++;
      exp_op = (c >= 1 && c <= busy_end) ? v.op : FOP_IDLE;
      if (fbu_op !== exp_op) op_bad++;
      if (wb_valid) begin
        wb_cnt++;
        if (wb_cnt == 1) begin wb_cycle = c; data_seen = wb_data; err_seen = wb_err; end
        wb_seen = 1'b1;
      end
      if (c > 0 && !busy) begin idle = c; break; end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    check({tag, " idle_cycle"}, idle, v.idle);
    check({tag, " stall_cycles"}, stall_cnt, v.stall);
    check({tag, " wb_pulses"}, wb_cnt, v.wb_cnt);
    check({tag, " fbu_op_bad_cycles"}, op_bad, 0);
    if (v.wb_cnt > 0) begin
      check({tag, " wb_cycle"}, wb_cycle, v.wb_cycle);
      check({tag, " wb_data"}, data_seen, v.data);
      check({tag, " wb_err"}, err_seen, v.err);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fbu_op"}, fbu_op, FOP_IDLE);
    check({tag, " fbu_rs"}, fbu_rs1 | fbu_rs2 | fbu_rs3, 0);
    check({tag, " wb_valid"}, wb_valid, 0);
    check({tag, " wb_data"}, wb_data, 0);
    check({tag, " wb_err"}, wb_err, 0);
    check({tag, " stall"}, stall, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    vec_t       vecs[9];
    vec_t       v;
    logic [4:0] b2b_op[6];
    logic       b2b_wb[6];
    int         e;

    // Fields: op, rs1, rs2, rs3, lat, flush_at, fixed_en, fixed_rd,
    //         wb_cnt, wb_cycle, data, err, stall, idle
    vecs[0] = '{FOP_ADD, 32'h3F800000, 32'h40000000, 32'h0, 3, 0, 1'b1, 32'h40400000,
                1, 4, 32'h40400000, 1'b0, 4, 5};
    vecs[1] = '{FOP_FEQ, 32'h40490FDB, 32'h40490FDB, 32'h0, 1, 0, 1'b1, 32'h1,
                1, 2, 32'h1, 1'b0, 2, 3};
    vecs[2] = '{5'd25, 32'h1111, 32'h2222, 32'h3333, 1, 0, 1'b1, 32'hDEAD,
                1, 1, 32'h0, 1'b1, 1, 2};
    vecs[3] = '{FOP_DIV, 32'h5, 32'h6, 32'h7, 0, 0, 1'b1, 32'hBEEF,
                1, 9, 32'h0, 1'b1, 9, 10};
    vecs[4] = '{FOP_DIV, 32'h40000000, 32'h3F800000, 32'h0, 6, 2, 1'b1, 32'hCAFE,
                0, 0, 32'h0, 1'b0, 2, 7};
    vecs[5] = '{FOP_MUL, 32'h9, 32'h8, 32'h7, 3, 3, 1'b1, 32'hF00D,
                0, 0, 32'h0, 1'b0, 3, 4};
    vecs[6] = '{FOP_FMADD, 32'hA, 32'hB, 32'hC, 8, 0, 1'b1, 32'h0BAD_F00D,
                1, 9, 32'h0BAD_F00D, 1'b0, 9, 10};
    vecs[7] = '{5'd22, 32'h1, 32'h2, 32'h3, 2, 0, 1'b1, 32'h77,
                1, 1, 32'h0, 1'b1, 1, 2};
    vecs[8] = '{FOP_FSQRT, 32'h40800000, 32'h0, 32'h0, 2, 0, 1'b1, 32'h12345678,
                1, 3, 32'h12345678, 1'b0, 3, 4};

    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; req_op = '0;
    req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
    stub_lat = 0; stub_fixed_en = 1'b0; stub_fixed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // A flushed request in IDLE neither stalls nor is accepted.
    @(posedge clk); #1 req_valid = 1'b1; flush = 1'b1; req_op = FOP_ADD;
    @(negedge clk);
    check("idle_flush stall", stall, 0);
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush busy", busy, 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hold wb_data", wb_data, 32'h12345678);
    check("hold wb_err", wb_err, 0);

    // Back-to-back combinational ops: FOP_IDLE must separate them.
    b2b_op = '{FOP_IDLE, FOP_FEQ, FOP_IDLE, FOP_IDLE, FOP_FLT, FOP_IDLE};
    b2b_wb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    stub_lat = 1; stub_fixed_en = 1'b1; stub_fixed = 32'h1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = (c < 3) ? FOP_FEQ : FOP_FLT;
      @(negedge clk);
      check($sformatf("b2b fbu_op c%0d", c), fbu_op, b2b_op[c]);
      check($sformatf("b2b wb_valid c%0d", c), wb_valid, b2b_wb[c]);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);

    // Reset while BUSY on a hung unit, then a normal transaction.
    @(posedge clk); #1;
    stub_lat = 0; req_valid = 1'b1; req_op = FOP_FCVT_S_W;
    req_rs1 = 32'hAAAA; req_rs2 = 32'hBBBB; req_rs3 = 32'hCCCC;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset busy", busy, 1);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(vecs[0], "post_reset");

    // Random transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      v.op  = 5'($urandom_range(0, 24));
      v.rs1 = $urandom; v.rs2 = $urandom; v.rs3 = $urandom;
      v.lat = $urandom_range(0, 10);
      v.fixed_en = 1'b0; v.fixed_rd = '0;
      v.flush_at = 0;
      e = (v.lat != 0 && v.lat <= T) ? v.lat : T;
      if (v.op <= FOP_LAST && ($urandom % 3) == 0)
        v.flush_at = $urandom_range(1, (e < T - 1) ? e : T - 1);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Pipeline-side controller that drives the floating-point unit (FBU) request/result interface from the EX stage. It latches one FP request, holds operation code and operands stable for the FBU until `fbu_done`, captures the result and returns it to writeback as a single-cycle pulse. It stalls the pipeline for the whole transaction and handles flush, illegal op codes and hung units.

## Interface
- `WIDTH`, 32, operand/result width
- `TIMEOUT`, 64, maximum BUSY cycles without `fbu_done` before abort (≥2)
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `req_valid`  in  1  EX stage presents an FP instruction
- `req_op`  in  5  FBU op code (0..21 legal)
- `req_rs1`, `req_rs2`, `req_rs3`  in  WIDTH each  source operands
- `flush`  in  1  squash the in-flight/presented instruction
- `fbu_op`  out  5  op code to FBU; `FOP_IDLE` (5'd31) when no transaction
- `fbu_rs1`, `fbu_rs2`, `fbu_rs3`  out  WIDTH each  operands to FBU, registered
- `fbu_rd`  in  WIDTH  FBU result
- `fbu_done`  in  1  FBU result valid (combinational in FBU from op)
- `stall`  out  1  hold IF/ID/EX
- `wb_valid`  out  1  one-cycle result pulse
- `wb_data`  out  WIDTH  result
- `wb_err`  out  1  qualifies `wb_valid`: illegal op or timeout
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY, DRAIN, RESP.
- IDLE: `fbu_op`=FOP_IDLE. If `req_valid && !flush`: latch op/operands. Legal op → BUSY. Op > 21 → RESP with `wb_err`=1, `wb_data`=0. `stall`=`req_valid && !flush` (combinational).
- BUSY: `fbu_op`/`fbu_rs*` = latched values, stable every cycle. Watchdog counts up from 0. `fbu_done`=1 → capture `fbu_rd` into result register, go to RESP. Counter reaches TIMEOUT-1 without done → RESP, `wb_err`=1, `wb_data`=0. `flush`=1 (and no `fbu_done` the same cycle) → DRAIN. If `flush` and `fbu_done` coincide, the result is discarded and the block goes to IDLE. `stall`=1.
- DRAIN: the op is held until `fbu_done` or timeout, so the FBU sub-unit is not left mid-operation. Then → IDLE without `wb_valid`. `stall`=0. A `req_valid` arriving in this state is not accepted until IDLE.
- RESP: `wb_valid`=1, `stall`=0, `fbu_op`=FOP_IDLE, → IDLE. `req_valid` in this cycle is the same instruction still held and is ignored.
- Combinational FBU ops (fclass, compare, min/max, sgnj) complete in the first BUSY cycle.
- FOP_IDLE is driven for at least one cycle between transactions, so every sub-unit sees its valid drop.

## Timing
- Reset, and reset mid-transaction: state IDLE, counter 0, `fbu_op`=5'd31, `fbu_rs*`=0, `wb_valid`=0, `wb_data`=0, `wb_err`=0, `stall`=0, `busy`=0. The FBU shares `rst_n`, so in-flight work is abandoned.
- Accept at cycle 0 (IDLE). BUSY starts at cycle 1. With done at BUSY cycle k (k≥1), `wb_valid` is high at cycle k+1.
- Minimum latency (combinational op): accept at cycle 0, `wb_valid` at cycle 2. Back-to-back throughput is one op per 3 cycles.
- Illegal op: `wb_valid`+`wb_err` at cycle 1.
- Timeout: `wb_valid`+`wb_err` exactly TIMEOUT cycles after BUSY entry.
- `wb_data`/`wb_err` hold their value until the next RESP.

## Structure
- Shared package `fpu_pkg`: FOP_* op code constants 0..21 (ADD, SUB, FCLASS, FCVT_S_W, …, FSQRT), `FOP_IDLE`=5'd31, `FOP_LAST`=5'd21, state encoding.
- The FBU decode uses the same op constants.
- One sub-module: `fpu_watchdog`, a clear/enable counter with a terminal-count output at TIMEOUT-1.

## Test plan
- FADD: op=0, rs1=0x3F800000, rs2=0x40000000, stub done after 3 cycles → `fbu_op`=0 held for 3 cycles, `wb_valid` once with `wb_data`=0x40400000, `stall` high for 4 cycles.
- FEQ: op=8, rs1=rs2=0x40490FDB, done immediately → `wb_valid` at cycle 2 with data 1, then `fbu_op`=31 for ≥1 cycle before the next op.
- Illegal op=25 → `wb_valid`+`wb_err` at cycle 1, `wb_data`=0, `fbu_op` stays 31 throughout.
- Hung unit (`fbu_done` never), TIMEOUT=8 → `wb_err` pulse 8 cycles after BUSY entry, then IDLE.
- `flush` in the 2nd BUSY cycle of an FDIV with done at cycle 6 → `fbu_op`=7 held until done, no `wb_valid`, `stall` low from the flush cycle, next request accepted after IDLE.
- `rst_n` low in BUSY → next cycle all outputs at reset values; a new request afterwards completes normally.
